// File: rtl/serdes_word_aligner.sv
// serdes_word_aligner: word-alignment controller downstream of an SDR ISERDESE2.
// Searches the deserialised word stream for TRAIN_PATTERN by pulsing BITSLIP. It
// declares lock after MATCH_COUNT consecutive matches, or declares failure after
// every phase has been tried.
// Ports:
//   clk_i        CLKDIV-domain clock
//   rst_ni       async active-low reset
//   start_i      start/restart alignment (honoured in IDLE, LOCKED, FAIL)
//   data_i       ISERDESE2 Q word, Q1 = bit 0
//   bitslip_o    one-cycle BITSLIP pulse to the ISERDESE2
//   data_o       data_i delayed by one cycle
//   data_valid_o data_o is aligned payload
//   locked_o     alignment achieved
//   fail_o       all phases tried without lock
//   slip_cnt_o   bitslips issued in the current attempt
module serdes_word_aligner #(
  parameter int unsigned WIDTH          = 8,
  parameter logic [7:0]  TRAIN_PATTERN  = 8'h5C,
  parameter int unsigned BITSLIP_SETTLE = 3,
  parameter int unsigned MATCH_COUNT    = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     start_i,
  input  logic [WIDTH-1:0]                         data_i,
  output logic                                     bitslip_o,
  output logic [WIDTH-1:0]                         data_o,
  output logic                                     data_valid_o,
  output logic                                     locked_o,
  output logic                                     fail_o,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] slip_cnt_o
);

  localparam int unsigned SW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned STW  = $clog2(BITSLIP_SETTLE + 1);
  localparam int unsigned MCW  = $clog2(MATCH_COUNT + 1);
  localparam logic [WIDTH-1:0] PAT = TRAIN_PATTERN[WIDTH-1:0];

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CHECK  = 3'd2,
    SLIP   = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [STW-1:0]   settle_q, settle_d;
  logic [MCW-1:0]   match_q, match_d;
  logic [SW-1:0]    slip_q, slip_d;
  logic [WIDTH-1:0] data_q;

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      settle_q <= '0;
      match_q  <= '0;
      slip_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      slip_q   <= slip_d;
      data_q   <= data_i;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    slip_d   = slip_q;
    unique case (state_q)
      IDLE, LOCKED, FAIL: begin
        if (start_i) begin
          state_d  = SETTLE;
          settle_d = STW'(BITSLIP_SETTLE);
          match_d  = '0;
          slip_d   = '0;
        end
      end
      SETTLE: begin
        // Counter is loaded on entry, so leaving at 1 gives exactly BITSLIP_SETTLE cycles
        if (settle_q <= STW'(1)) begin
          state_d = CHECK;
          match_d = '0;
        end else begin
          settle_d = settle_q - STW'(1);
        end
      end
      CHECK: begin
        if (data_i == PAT) begin
          match_d = match_q + MCW'(1);
          if (match_q == MCW'(MATCH_COUNT - 1)) state_d = LOCKED;
        end else begin
          match_d = '0;
          // Last phase already tried: give up instead of wrapping slip_cnt
          if (slip_q == SW'(WIDTH - 1)) state_d = FAIL;
          else                          state_d = SLIP;
        end
      end
      SLIP: begin
        state_d  = SETTLE;
        settle_d = STW'(BITSLIP_SETTLE);
        slip_d   = slip_q + SW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register
  assign bitslip_o    = (state_q == SLIP);
  assign locked_o     = (state_q == LOCKED);
  assign data_valid_o = (state_q == LOCKED);
  assign fail_o       = (state_q == FAIL);
  assign slip_cnt_o   = slip_q;
  assign data_o       = data_q;

endmodule

// File: tb/tb_serdes_word_aligner.sv
// Self-checking bench for serdes_word_aligner with a rotating ISERDES data model.
module tb_serdes_word_aligner;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [7:0] data_i;
  logic       bitslip_o;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       locked_o;
  logic       fail_o;
  logic [2:0] slip_cnt_o;

  always #5 clk_i = ~clk_i;

  serdes_word_aligner dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .data_i      (data_i),
    .bitslip_o   (bitslip_o),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .locked_o    (locked_o),
    .fail_o      (fail_o),
    .slip_cnt_o  (slip_cnt_o)
  );

  int         pass_cnt = 0;
  int         fail_cnt = 0;
  int         total    = 0;
  logic [7:0] exp_q[$];

  logic [7:0] base;
  bit         rot_en;
  int         rot0;
  int         nslip;
  bit         force_on;
  logic [7:0] force_val;
  int         cyc;
  int         last_pulse;
  int         pulses;
  bit         locked_seen;
  int         n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic drive_model();
    if (force_on)    data_i = force_val;
    else if (rot_en) data_i = rotl(base, (rot0 + nslip) % 8);
    else             data_i = base;
  endtask

  // One clock: scoreboard data_o, track bitslip pulses, update the ISERDES model
  task automatic tick();
    if (rst_ni) exp_q.push_back(data_i);
    @(posedge clk_i);
    #1;
    cyc++;
    if (exp_q.size() > 0) chk("data_o", 32'(data_o), 32'(exp_q.pop_front()));
    chk("lock_fail_excl", 32'(locked_o & fail_o), 32'(0));
    if (bitslip_o) begin
      if (last_pulse >= 0) chk("slip_spacing", 32'(cyc - last_pulse), 32'(5));
      last_pulse = cyc;
      pulses++;
      nslip++;
    end
    if (locked_o) locked_seen = 1'b1;
    drive_model();
  endtask

  task automatic start_pulse();
    start_i     = 1'b1;
    pulses      = 0;
    last_pulse  = -1;
    locked_seen = 1'b0;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic wait_for(input string tag, input bit want_fail, input int limit, output int cnt);
    cnt = 0;
    while (!(want_fail ? fail_o : locked_o) && cnt < limit) begin
      tick();
      cnt++;
    end
    chk(tag, 32'(want_fail ? fail_o : locked_o), 32'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({bitslip_o, data_o, data_valid_o, locked_o, fail_o, slip_cnt_o}), 32'(0));
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; data_i = '0;
    base = 8'h5C; rot_en = 1'b0; rot0 = 0; nslip = 0; force_on = 1'b0; force_val = '0;
    cyc = 0; last_pulse = -1; pulses = 0; locked_seen = 1'b0; n = 0;

    // 1. reset with random inputs
    for (int i = 0; i < 4; i++) begin
      data_i  = 8'($urandom);
      start_i = 1'($urandom);
      @(posedge clk_i);
      #1;
      chk_all_zero("reset_outputs");
    end
    start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive_model();
    repeat (3) tick();
    chk("idle_locked", 32'(locked_o), 32'(0));

    // 2. perfectly aligned stream
    start_pulse();
    wait_for("lock_aligned", 1'b0, 60, n);
    chk("lock_latency", 32'(n), 32'(19));
    chk("aligned_slip_cnt", 32'(slip_cnt_o), 32'(0));
    chk("aligned_pulses", 32'(pulses), 32'(0));
    chk("aligned_valid", 32'(data_valid_o), 32'(1));
    start_pulse();
    chk("restart_locked_drop", 32'(locked_o), 32'(0));
    chk("restart_valid_drop", 32'(data_valid_o), 32'(0));
    wait_for("relock_aligned", 1'b0, 60, n);
    chk("relock_latency", 32'(n), 32'(19));

    // 3. pattern rotated, model rotates once per bitslip
    rot_en = 1'b1; rot0 = 5; nslip = 0;
    drive_model();
    tick();
    start_pulse();
    wait_for("lock_rotated", 1'b0, 200, n);
    chk("rotated_pulses", 32'(pulses), 32'(3));
    chk("rotated_slip_cnt", 32'(slip_cnt_o), 32'(3));
    chk("rotated_data", 32'(data_o), 32'(8'h5C));
    chk("rotated_valid", 32'(data_valid_o), 32'(1));

    // 4. no pattern present: exhaust all phases
    rot_en = 1'b0; base = 8'h00;
    drive_model();
    tick();
    start_pulse();
    wait_for("fail_reached", 1'b1, 200, n);
    chk("fail_pulses", 32'(pulses), 32'(7));
    chk("fail_slip_cnt", 32'(slip_cnt_o), 32'(7));
    chk("fail_never_locked", 32'(locked_seen), 32'(0));
    start_pulse();
    chk("fail_restart_slip_cnt", 32'(slip_cnt_o), 32'(0));
    chk("fail_restart_fail", 32'(fail_o), 32'(0));
    base = 8'h5C;
    drive_model();
    wait_for("lock_after_fail", 1'b0, 60, n);

    // 5. one corrupted word after 10 matches
    start_pulse();
    repeat (13) tick();
    force_val = 8'hA5; force_on = 1'b1;
    drive_model();
    force_on = 1'b0;
    tick();
    chk("corrupt_slip", 32'(bitslip_o), 32'(1));
    wait_for("lock_after_corrupt", 1'b0, 60, n);
    chk("corrupt_relock_latency", 32'(n), 32'(20));
    chk("corrupt_pulses", 32'(pulses), 32'(1));
    chk("corrupt_slip_cnt", 32'(slip_cnt_o), 32'(1));

    // 6. reset during SLIP
    base = 8'h00;
    drive_model();
    start_pulse();
    n = 0;
    while (!bitslip_o && n < 20) begin
      tick();
      n++;
    end
    chk("reached_slip", 32'(bitslip_o), 32'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_bitslip_drop", 32'(bitslip_o), 32'(0));
    chk_all_zero("async_reset_outputs");
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    base = 8'h5C;
    drive_model();
    pulses = 0; last_pulse = -1;
    repeat (6) tick();
    chk("post_reset_idle_pulses", 32'(pulses), 32'(0));
    chk("post_reset_idle_state", 32'({locked_o, fail_o, data_valid_o, slip_cnt_o}), 32'(0));
    start_pulse();
    wait_for("lock_after_reset", 1'b0, 60, n);
    chk("post_reset_lock_latency", 32'(n), 32'(19));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
